// File: rtl/register_file_param.sv
// Parameterised 2R/1W register file with a sequential clear engine.
// Optional zero register: define REG_FILE_ZERO_REG_EN.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic                  CLEAR,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CLR  = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_d1;
  logic [DATA_WIDTH-1:0] r_d2;
  logic                  r_vld;

  logic                  w_idle;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic                  w_wr_ok;
  logic                  w_z1;
  logic                  w_z2;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

`ifdef REG_FILE_ZERO_REG_EN
  // Address 0 is hardwired: writes dropped, reads forced to zero.
  assign w_wr_ok = |ADDR_W;
  assign w_z1    = ~|ADDR_R1;
  assign w_z2    = ~|ADDR_R2;
`else
  assign w_wr_ok = 1'b1;
  assign w_z1    = 1'b0;
  assign w_z2    = 1'b0;
`endif

  assign w_idle  = (r_state == S_IDLE);
  assign w_rd_en = w_idle & READ & ~CLEAR;
  assign w_wr_en = w_idle & WRITE & ~CLEAR & w_wr_ok;
  assign w_last  = &r_cnt;

  // Write-first bypass keeps same-cycle read/write coherent.
  always_comb begin
    w_rd1 = r_mem[ADDR_R1];
    w_rd2 = r_mem[ADDR_R2];
    if (w_wr_en && (ADDR_W == ADDR_R1))
      w_rd1 = DATA_W;
    if (w_wr_en && (ADDR_W == ADDR_R2))
      w_rd2 = DATA_W;
    if (w_z1)
      w_rd1 = '0;
    if (w_z2)
      w_rd2 = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (CLEAR) begin
            r_state <= S_CLR;
            r_cnt   <= '0;
          end
        end
        S_CLR: begin
          // Counter wraps to 0 on the same edge that exits.
          r_cnt <= r_cnt + 1'b1;
          if (w_last)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (r_state == S_CLR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      r_mem[ADDR_W] <= DATA_W;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_d1  <= '0;
      r_d2  <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_rd_en;
      if (w_rd_en) begin
        r_d1 <= w_rd1;
        r_d2 <= w_rd2;
      end
    end
  end

  assign DATA_R1  = r_d1;
  assign DATA_R2  = r_d2;
  assign RD_VALID = r_vld;
  assign BUSY     = (r_state == S_CLR);

endmodule
